// File: rtl/mini_alu_sequencer_if.sv
// ALU handshake bundle: operands and opcode out, start/done strobes, result back.
// The sequencer uses the master side and the ALU core uses the slave side.
interface mini_alu_sequencer_if #(
  parameter int OPW = 5
);
  logic [OPW-1:0] alu_a;
  logic [OPW-1:0] alu_b;
  logic [1:0]     alu_op;
  logic           alu_start;
  logic           alu_done;
  logic [9:0]     alu_result;

  modport master (
    output alu_a, alu_b, alu_op, alu_start,
    input  alu_done, alu_result
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_start,
    output alu_done, alu_result
  );
endinterface

// File: rtl/mini_alu_sequencer.sv
// Front-panel sequencer: collects A, B and opcode from the switches on key presses,
// runs one ALU transaction with a timeout and shows the result on the LEDs.
module mini_alu_sequencer #(
  parameter int OPW     = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           switches,
  input  logic                 key_n,
  mini_alu_sequencer_if.master alu,
  output logic [9:0]           leds,
  output logic [2:0]           stage,
  output logic                 busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_SHOW    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  state_e           state_q;
  logic             key_s1_q, key_s2_q, key_prev_q;
  logic             press_d, press_q;
  logic [OPW-1:0]   a_q, b_q;
  logic [1:0]       op_q;
  logic             start_q;
  logic [9:0]       result_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronized falling edge of the key, registered so a press lands two edges after capture.
  assign press_d = !key_s2_q && key_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      key_prev_q <= 1'b1;
      press_q    <= 1'b0;
    end else begin
      key_s1_q   <= key_n;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      press_q    <= press_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_LOAD_A: if (press_q) begin
          a_q     <= switches[OPW-1:0];
          state_q <= S_LOAD_B;
        end
        S_LOAD_B: if (press_q) begin
          b_q     <= switches[OPW-1:0];
          state_q <= S_LOAD_OP;
        end
        S_LOAD_OP: if (press_q) begin
          op_q    <= switches[1:0];
          start_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the last allowed cycle still counts as success.
          if (alu.alu_done) begin
            result_q <= alu.alu_result;
            state_q  <= S_SHOW;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_ERR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SHOW, S_ERR: if (press_q) state_q <= S_LOAD_A;
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  // NOTE: leds gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    leds = switches;
    case (state_q)
      S_ISSUE, S_WAIT: leds = 10'h000;
      S_SHOW:          leds = result_q;
      S_ERR:           leds = 10'h3FF;
      default:         leds = switches;
    endcase
  end

  assign stage         = state_q;
  assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign alu.alu_a     = a_q;
  assign alu.alu_b     = b_q;
  assign alu.alu_op    = op_q;
  assign alu.alu_start = start_q;

endmodule

// File: tb/tb_mini_alu_sequencer.sv
// Randomized bench for mini_alu_sequencer: an ALU responder with programmable latency,
// a reference model filling a scoreboard, and a monitor checking each completed operation.
module tb_mini_alu_sequencer;
  localparam int OPW     = 5;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] switches;
  logic       key_n;
  logic [9:0] leds;
  logic [2:0] stage;
  logic       busy;

  mini_alu_sequencer_if #(.OPW(OPW)) alu_if ();

  mini_alu_sequencer #(.OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .key_n    (key_n),
    .alu      (alu_if.master),
    .leds     (leds),
    .stage    (stage),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     stage;
    logic [9:0]     leds;
    int             lat;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [1:0]     op;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   starts = 0;
  int   wait_entry = 0;
  logic [2:0] prev_stage = 3'd0;

  // Responder configuration: delay 0 means the ALU never answers.
  int         cfg_delay = 0;
  bit         cfg_ovr = 1'b0;
  logic [9:0] cfg_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] alu_f(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a ^ b;
      1:       r = a + b;
      2:       r = a * b;
      default: r = a | b;
    endcase
    return 10'(r);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ALU core model.
  initial begin : responder
    int         d;
    logic [9:0] r;
    alu_if.alu_done   = 1'b0;
    alu_if.alu_result = '0;
    forever begin
      @(negedge clk);
      if (alu_if.alu_start === 1'b1 && cfg_delay > 0) begin
        d = cfg_delay;
        r = cfg_ovr ? cfg_val : alu_f(int'(alu_if.alu_a), int'(alu_if.alu_b), int'(alu_if.alu_op));
        repeat (d) @(negedge clk);
        alu_if.alu_done   = 1'b1;
        alu_if.alu_result = r;
        @(negedge clk);
        alu_if.alu_done   = 1'b0;
        alu_if.alu_result = '0;
      end
    end
  end

  // Monitor: every WAIT exit into SHOW/ERR is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (alu_if.alu_start === 1'b1) starts++;
    if (prev_stage == 3'd3 && stage == 3'd4) wait_entry = cyc;
    if (prev_stage == 3'd4 && (stage == 3'd5 || stage == 3'd6)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: operation completed with stage %0d, none expected", stage);
      end else begin
        e = sb.pop_front();
        check("res_stage", 32'(stage), 32'(e.stage));
        check("res_leds", 32'(leds), 32'(e.leds));
        check("res_latency", cyc - wait_entry, e.lat);
        check("res_alu_a", 32'(alu_if.alu_a), 32'(e.a));
        check("res_alu_b", 32'(alu_if.alu_b), 32'(e.b));
        check("res_alu_op", 32'(alu_if.alu_op), 32'(e.op));
        check("res_start_count", starts, 1);
      end
      starts = 0;
    end
    prev_stage = stage;
  end

  task automatic press(input logic [9:0] sw, input int hold);
    switches = sw;
    @(negedge clk);
    key_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_stage(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (stage !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(stage), 32'(s));
  endtask

  // Reference model: outcome depends only on the entered values and the ALU latency.
  task automatic run_op(input logic [9:0] sw_a, input logic [9:0] sw_b, input logic [9:0] sw_op,
                        input int d, input bit ovr, input logic [9:0] val, input bit glitch);
    exp_t       e;
    logic [9:0] sw_back;
    e.a  = sw_a[OPW-1:0];
    e.b  = sw_b[OPW-1:0];
    e.op = sw_op[1:0];
    if (d >= 1 && d <= TIMEOUT) begin
      e.stage = 3'd5;
      e.leds  = ovr ? val : alu_f(int'(e.a), int'(e.b), int'(e.op));
      e.lat   = d;
    end else begin
      e.stage = 3'd6;
      e.leds  = 10'h3FF;
      e.lat   = TIMEOUT;
    end
    sb.push_back(e);
    cfg_delay = d;
    cfg_ovr   = ovr;
    cfg_val   = val;
    wait_stage(3'd0, 5, "op_idle");
    press(sw_a, 1);
    press(sw_b, 1);
    press(sw_op, 1);
    if (glitch) begin
      press(10'($urandom), 1);
      check("glitch_busy", 32'(busy), 32'(1));
    end
    wait_stage(e.stage, 60, "op_done");
    sw_back = 10'($urandom);
    press(sw_back, 1);
    check("back_stage", 32'(stage), 32'(0));
    check("back_leds", 32'(leds), 32'(sw_back));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int         d;
    logic [9:0] sa, sb_sw, so;
    rst      = 1'b1;
    key_n    = 1'b1;
    switches = 10'h2A5;
    repeat (3) @(negedge clk);
    check("rst_stage", 32'(stage), 32'(0));
    check("rst_alu_a", 32'(alu_if.alu_a), 32'(0));
    check("rst_alu_start", 32'(alu_if.alu_start), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;

    repeat (1000) @(negedge clk);
    check("idle_stage", 32'(stage), 32'(0));
    check("idle_leds", 32'(leds), 32'h2A5);
    check("idle_no_start", starts, 0);

    // Held key in LOAD_A: one advance only, none on release.
    switches = 10'd5;
    key_n    = 1'b0;
    repeat (50) @(negedge clk);
    check("hold_advance", 32'(stage), 32'(1));
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    check("release_no_advance", 32'(stage), 32'(1));
    sb.push_back('{stage: 3'd5, leds: 10'd14, lat: 3, a: 5'd5, b: 5'd9, op: 2'd1});
    cfg_delay = 3;
    cfg_ovr   = 1'b0;
    press(10'd9, 1);
    press(10'd1, 1);
    wait_stage(3'd5, 40, "basic_show");
    check("basic_leds", 32'(leds), 32'd14);
    press(10'h0F0, 1);
    check("basic_back", 32'(stage), 32'(0));

    run_op(10'd3, 10'd4, 10'd2, 0, 1'b0, 10'd0, 1'b0);
    run_op(10'd7, 10'd2, 10'd3, TIMEOUT, 1'b1, 10'd7, 1'b0);

    // Reset during WAIT; the stale completion must be ignored.
    cfg_delay = 6;
    cfg_ovr   = 1'b1;
    cfg_val   = 10'd99;
    press(10'd3, 1);
    press(10'd4, 1);
    press(10'd2, 1);
    check("rst_wait_busy", 32'(stage), 32'(4));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wait_stage", 32'(stage), 32'(0));
    @(negedge clk);
    rst      = 1'b0;
    switches = 10'h155;
    repeat (10) @(negedge clk);
    check("abort_stage", 32'(stage), 32'(0));
    check("abort_alu_a", 32'(alu_if.alu_a), 32'(0));
    check("abort_alu_b", 32'(alu_if.alu_b), 32'(0));
    check("abort_alu_op", 32'(alu_if.alu_op), 32'(0));
    check("abort_leds", 32'(leds), 32'h155);
    starts = 0;

    for (int i = 0; i < 40; i++) begin
      sa    = 10'($urandom);
      sb_sw = 10'($urandom);
      so    = 10'($urandom);
      d     = int'($urandom_range(1, 20));
      run_op(sa, sb_sw, so, d, ($urandom_range(0, 3) == 0), 10'($urandom),
             (d >= 10) && ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mini_alu_sequencer.md
Name: mini_alu_sequencer

Overview:
- Front-panel controller for the mini ALU datapath on the lab board.
- Walks the user through a fixed sequence: operand A, then operand B, then opcode, all entered on the 10 slide switches and confirmed with one push-button.
- Issues a start/done handshake to the ALU, waits with a timeout, latches the result and drives it to the LEDs.
- Sits between the board I/O (switches, key, leds) and the ALU core.

Parameters:
- OPW, 5, operand width in bits (1..10); operands are taken from switches[OPW-1:0].
- TIMEOUT, 16, maximum cycles spent in WAIT for alu_done before entering ERR (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- switches  input  10  raw slide-switch values (static, no sync required).
- key_n  input  1  raw push-button, active-low, asynchronous to clk.
- alu_a  output  OPW  operand A to ALU.
- alu_b  output  OPW  operand B to ALU.
- alu_op  output  2  opcode to ALU.
- alu_start  output  1  one-cycle start pulse.
- alu_done  input  1  ALU completion strobe, valid one cycle.
- alu_result  input  10  ALU result, valid in the same cycle as alu_done.
- leds  output  10  display.
- stage  output  3  current state encoding.
- busy  output  1  high in ISSUE and WAIT.

Behaviour:
- Reset values (asynchronous): state=LOAD_A, alu_a=0, alu_b=0, alu_op=0, alu_start=0, result register=0, timeout counter=0, both key synchronizer flops=1, press-history flop=1, busy=0.
- Key handling:
  - 2-flop synchronizer on key_n.
  - press = sync_out==0 && prev==1, i.e. a falling edge of the synchronized key.
  - One press per physical falling edge; holding the key generates no repeats.
  - No debounce (board keys are hardware-debounced).
- State encoding on stage: LOAD_A=0, LOAD_B=1, LOAD_OP=2, ISSUE=3, WAIT=4, SHOW=5, ERR=6.
- Transitions:
  - LOAD_A: on press, alu_a <= switches[OPW-1:0], go to LOAD_B.
  - LOAD_B: on press, alu_b <= switches[OPW-1:0], go to LOAD_OP.
  - LOAD_OP: on press, alu_op <= switches[1:0], go to ISSUE.
  - ISSUE: single cycle; alu_start=1 for exactly this cycle; counter <= 0; go to WAIT.
  - WAIT, alu_done=1: result <= alu_result, go to SHOW.
  - WAIT, alu_done=0 and counter==TIMEOUT-1: go to ERR.
  - WAIT, otherwise: counter++.
  - SHOW: on press, go to LOAD_A. Operand and opcode registers are retained, not cleared.
  - ERR: on press, go to LOAD_A.
- Priority and corner cases:
  - alu_done on the same cycle as counter==TIMEOUT-1: done wins, go to SHOW.
  - alu_done outside WAIT (including in ISSUE): ignored, result unchanged.
  - Presses during ISSUE/WAIT: ignored.
  - alu_start is registered, so it is high in the cycle stage==3.
- Latency: key_n sampled low at edge N → press asserted after edge N+2 → state advances at edge N+3.
- leds:
  - LOAD_A/LOAD_B/LOAD_OP: live echo of switches.
  - ISSUE/WAIT: 10'h000.
  - SHOW: result.
  - ERR: 10'h3FF.
  - leds is combinational from state and registers.
- busy = (state==ISSUE || state==WAIT).
- Reset mid-operation (any state, including WAIT): immediate return to reset values. A later alu_done from the aborted operation is ignored because state is LOAD_A.

Test Plan:
- Reset, then 1,000 idle cycles → stage=0, leds mirror switches (drive 10'h2A5 → leds=10'h2A5), alu_start never asserted.
- Full operation with ALU model replying 3 cycles after start:
  - Sequence: switches=5 + press, switches=9 + press, switches=1 + press.
  - Required: alu_a=5, alu_b=9, alu_op=1; exactly one alu_start cycle; stage 3→4→5.
  - Model returns 10'd14 → leds=14.
- Key held low for 50 cycles in LOAD_A → exactly one advance (stage=1); key release gives no advance.
- ALU never responds, TIMEOUT=16 → stage=6 exactly 16 cycles after the WAIT entry edge, leds=10'h3FF; next press → stage=0.
- alu_done asserted on the final timeout cycle (counter=15) with result 10'd7 → stage=5, leds=7, not ERR.
- rst pulsed in WAIT, then alu_done with result 10'd99 → stage=0, all registers cleared, result not captured, leds echo switches.
